// File: rtl/dram_resp_if.sv
// dram_resp_if: engine request/response, host access and statistics signals of the DRAM responder
interface dram_resp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int CNT_WIDTH  = 32
);
  logic                  acc_start;
  logic                  acc_done;
  logic                  dram_en_rd;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  dram_valid;
  logic                  dram_en_wr;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ack;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  host_rvalid;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  rd_cnt;
  logic [CNT_WIDTH-1:0]  wr_cnt;
  modport master (
    output acc_start, acc_done, dram_en_rd, addr_in, dram_en_wr, addr_out, data_out,
           host_req, host_we, host_addr, host_wdata,
    input  data_in, dram_valid, host_ack, host_rdata, host_rvalid, busy, rd_cnt, wr_cnt
  );
  modport slave (
    input  acc_start, acc_done, dram_en_rd, addr_in, dram_en_wr, addr_out, data_out,
           host_req, host_we, host_addr, host_wdata,
    output data_in, dram_valid, host_ack, host_rdata, host_rvalid, busy, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/dram_resp.sv
// dram_resp: word store serving engine reads/writes (1-cycle read latency) and host access, arbitrated by an IDLE/RUN/DRAIN FSM; ports: clk, srst, bus (dram_resp_if.slave)
module dram_resp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int CNT_WIDTH  = 32
) (
  input logic      clk,
  input logic      srst,
  dram_resp_if.slave bus
);
  typedef enum logic [2:0] {ST_IDLE = 3'b001, ST_RUN = 3'b010, ST_DRAIN = 3'b100} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic rd_acc, wr_acc, host_srv;
  always_comb begin
    state_nxt = state == ST_IDLE ? (bus.acc_start ? ST_RUN : ST_IDLE) :
                state == ST_RUN  ? (bus.acc_done ? ST_DRAIN : ST_RUN) : ST_IDLE;
    rd_acc   = state == ST_RUN && bus.dram_en_rd;
    wr_acc   = state == ST_RUN && bus.dram_en_wr;
    host_srv = state == ST_IDLE && bus.host_req;
    bus.busy = state != ST_IDLE;
  end
  // engine and host writes live in disjoint states, so one port suffices
  always_ff @(posedge clk)
    if (!srst) begin
      if (wr_acc) mem[bus.addr_out] <= bus.data_out;
      else if (host_srv && bus.host_we) mem[bus.host_addr] <= bus.host_wdata;
    end
  always_ff @(posedge clk)
    if (srst) begin
      state           <= ST_IDLE;
      bus.data_in     <= '0;
      bus.dram_valid  <= 1'b0;
      bus.host_ack    <= 1'b0;
      bus.host_rdata  <= '0;
      bus.host_rvalid <= 1'b0;
      bus.rd_cnt      <= '0;
      bus.wr_cnt      <= '0;
    end else begin
      state          <= state_nxt;
      bus.dram_valid <= rd_acc;
      // write-first bypass keeps read-modify-write streams coherent
      if (rd_acc) bus.data_in <= (wr_acc && bus.addr_out == bus.addr_in) ? bus.data_out : mem[bus.addr_in];
      bus.host_ack    <= host_srv;
      bus.host_rvalid <= host_srv && !bus.host_we;
      if (host_srv && !bus.host_we) bus.host_rdata <= mem[bus.host_addr];
      if (state == ST_IDLE && bus.acc_start) begin
        bus.rd_cnt <= '0;
        bus.wr_cnt <= '0;
      end else begin
        if (rd_acc && !(&bus.rd_cnt)) bus.rd_cnt <= bus.rd_cnt + CNT_WIDTH'(1);
        if (wr_acc && !(&bus.wr_cnt)) bus.wr_cnt <= bus.wr_cnt + CNT_WIDTH'(1);
      end
    end
endmodule

// File: tb/tb_dram_resp.sv
// tb_dram_resp: directed + randomized checks of dram_resp against an associative-array store model
module tb_dram_resp;
  localparam int CW = 4;
  localparam int CMAX = 15;
  logic clk = 1'b0;
  logic srst;
  int checks = 0;
  int failures = 0;
  logic [31:0] model [int];
  int kaddr [$];
  logic [31:0] exp_din;
  int exp_rd, exp_wr;
  bit run;
  dram_resp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .CNT_WIDTH(CW)) bus ();
  dram_resp #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .CNT_WIDTH(CW)) dut (.clk(clk), .srst(srst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] rdm(int a);
    return model.exists(a) ? model[a] : 32'h0;
  endfunction
  task automatic idle_inputs();
    bus.acc_start = 0; bus.acc_done = 0;
    bus.dram_en_rd = 0; bus.dram_en_wr = 0;
    bus.host_req = 0; bus.host_we = 0;
  endtask
  task automatic host_wr(int a, logic [31:0] d);
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 18'(a); bus.host_wdata = d;
    model[a] = d;
    step();
    chk("host_wr_ack", bus.host_ack, 1);
    chk("host_wr_rvalid", bus.host_rvalid, 0);
    bus.host_req = 0;
  endtask
  task automatic host_rd(int a);
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 18'(a);
    step();
    chk("host_rd_ack", bus.host_ack, 1);
    chk("host_rd_rvalid", bus.host_rvalid, 1);
    chk("host_rdata", bus.host_rdata, rdm(a));
    bus.host_req = 0;
  endtask
  task automatic eng(bit rd, int ra, bit wr, int wa, logic [31:0] wd);
    bus.dram_en_rd = rd; bus.addr_in = 18'(ra);
    bus.dram_en_wr = wr; bus.addr_out = 18'(wa); bus.data_out = wd;
    if (run && rd) begin
      exp_din = (wr && wa == ra) ? wd : rdm(ra);
      exp_rd = exp_rd < CMAX ? exp_rd + 1 : CMAX;
    end
    if (run && wr) begin
      model[wa] = wd;
      exp_wr = exp_wr < CMAX ? exp_wr + 1 : CMAX;
    end
    step();
    chk("dram_valid", bus.dram_valid, run && rd);
    chk("data_in", bus.data_in, exp_din);
    bus.dram_en_rd = 0; bus.dram_en_wr = 0;
  endtask
  task automatic chk_cnt(string tag);
    chk({tag, "_rd_cnt"}, bus.rd_cnt, exp_rd);
    chk({tag, "_wr_cnt"}, bus.wr_cnt, exp_wr);
  endtask
  initial begin
    idle_inputs();
    bus.addr_in = 0; bus.addr_out = 0; bus.data_out = 0; bus.host_addr = 0; bus.host_wdata = 0;
    exp_din = 0; exp_rd = 0; exp_wr = 0; run = 0;
    srst = 1;
    step(); step();
    srst = 0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_dram_valid", bus.dram_valid, 0);
    chk("rst_data_in", bus.data_in, 0);
    chk("rst_host_ack", bus.host_ack, 0);
    chk("rst_host_rvalid", bus.host_rvalid, 0);
    chk("rst_host_rdata", bus.host_rdata, 0);
    chk_cnt("rst");
    host_wr(5, 32'h11);
    host_rd(5);
    host_wr(7, 32'h55);
    host_wr(9, 32'h99);
    host_wr('h20000, 32'h100);
    host_wr('h20001, $urandom);
    kaddr = '{5, 7, 9, 'h20000, 'h20001};
    for (int i = 0; i < 8; i++) begin
      host_wr('h100 + i, $urandom);
      kaddr.push_back('h100 + i);
    end
    bus.host_req = 1; bus.host_we = 0;
    for (int i = 0; i < 4; i++) begin
      int a = kaddr[$urandom_range(0, kaddr.size() - 1)];
      bus.host_addr = 18'(a);
      step();
      chk("b2b_ack", bus.host_ack, 1);
      chk("b2b_rdata", bus.host_rdata, rdm(a));
    end
    bus.host_req = 0;
    step();
    chk("host_ack_drop", bus.host_ack, 0);
    bus.acc_done = 1;
    step();
    bus.acc_done = 0;
    chk("done_in_idle", bus.busy, 0);
    eng(0, 0, 1, 5, 32'hDEAD);
    host_rd(5);
    bus.acc_start = 1;
    step();
    bus.acc_start = 0;
    run = 1;
    chk("start_busy", bus.busy, 1);
    eng(1, 5, 0, 0, 0);
    eng(0, 0, 0, 0, 0);
    chk_cnt("after_read");
    eng(1, 'h20000, 0, 0, 0);
    eng(1, 'h20001, 1, 'h20000, exp_din + 32'd4);
    eng(1, 7, 1, 7, 32'hAB);
    eng(0, 0, 0, 0, 0);
    chk_cnt("rmw");
    for (int i = 0; i < 24; i++) begin
      int ra = kaddr[$urandom_range(0, kaddr.size() - 1)];
      int wa = ($urandom % 3 == 0) ? ra : kaddr[$urandom_range(0, kaddr.size() - 1)];
      eng(1'($urandom), ra, 1'($urandom), wa, $urandom);
    end
    chk_cnt("random");
    bus.acc_start = 1;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 18'('h20000);
    step();
    bus.acc_start = 0;
    chk("run_no_ack", bus.host_ack, 0);
    chk_cnt("start_ignored");
    step();
    chk("run_no_ack2", bus.host_ack, 0);
    bus.acc_done = 1;
    eng(0, 0, 1, 9, 32'h1234_5678);
    bus.acc_done = 0;
    run = 0;
    chk("drain_busy", bus.busy, 1);
    chk("drain_no_ack", bus.host_ack, 0);
    eng(1, 'h20000, 1, 'h20000, 32'hBAD0_BAD0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_reentry_no_ack", bus.host_ack, 0);
    chk_cnt("drain_ignored");
    step();
    chk("arb_ack", bus.host_ack, 1);
    chk("arb_rdata", bus.host_rdata, rdm('h20000));
    bus.host_req = 0;
    host_rd(9);
    host_rd(7);
    bus.acc_start = 1;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 18'(5);
    step();
    bus.acc_start = 0; bus.host_req = 0;
    run = 1; exp_rd = 0; exp_wr = 0;
    chk("start_host_ack", bus.host_ack, 1);
    chk("start_host_rdata", bus.host_rdata, rdm(5));
    chk_cnt("restart_clear");
    for (int i = 0; i < 3; i++) eng(0, 0, 1, 'h300 + i, $urandom);
    chk_cnt("pre_reset");
    bus.dram_en_rd = 1; bus.addr_in = 18'(5);
    srst = 1;
    step();
    srst = 0; bus.dram_en_rd = 0;
    run = 0; exp_rd = 0; exp_wr = 0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_valid", bus.dram_valid, 0);
    chk("mid_rst_data_in", bus.data_in, 0);
    chk_cnt("mid_rst");
    for (int i = 0; i < 3; i++) host_rd('h300 + i);
    host_rd(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
